// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for four switch banks sharing one 3-bit LED output.
// Holds each grant for at most DWELL cycles; grant, sel and led are registered together.
module mux_rr_arbiter #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [2:0] sw0,
  input  logic [2:0] sw1,
  input  logic [2:0] sw2,
  input  logic [2:0] sw3,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic [2:0] led,
  output logic       busy
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  localparam logic [7:0] CntInit = 8'(DWELL - 1);

  state_e     r_state, w_state_d;
  logic [1:0] r_idx, w_idx_d;
  logic [1:0] r_last, w_last_d;
  logic [7:0] r_cnt, w_cnt_d;
  logic [3:0] r_grant, w_grant_d;
  logic [1:0] r_sel, w_sel_d;
  logic [2:0] r_led, w_led_d;
  logic [2:0] w_sw_next;
  logic       w_hold_next;

  // First requester after p in rotation order; p itself is checked last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] c;
    rr_pick = p;
    for (int k = 4; k >= 1; k--) begin
      c = p + 2'(k);
      if (r[c]) rr_pick = c;
    end
  endfunction

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_last_d  = r_last;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (|req) begin
          w_idx_d   = rr_pick(req, r_last);
          w_cnt_d   = CntInit;
          w_state_d = StHold;
        end
      end
      StHold: begin
        if (!req[r_idx] || (r_cnt == 8'd0)) begin
          w_last_d = r_idx;
          // Any request left (others, or the holder itself) gives a back-to-back handover.
          if (|req) begin
            w_idx_d = rr_pick(req, r_idx);
            w_cnt_d = CntInit;
          end else begin
            w_state_d = StIdle;
          end
        end else begin
          w_cnt_d = r_cnt - 8'd1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_sw_next = sw0;
    unique case (w_idx_d)
      2'd0: w_sw_next = sw0;
      2'd1: w_sw_next = sw1;
      2'd2: w_sw_next = sw2;
      2'd3: w_sw_next = sw3;
      default: w_sw_next = sw0;
    endcase
    w_hold_next = (w_state_d == StHold);
    w_grant_d   = w_hold_next ? (4'b0001 << w_idx_d) : 4'b0000;
    w_sel_d     = w_hold_next ? w_idx_d : r_sel;
    w_led_d     = w_hold_next ? w_sw_next : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_idx   <= 2'd0;
      r_last  <= 2'd3;
      r_cnt   <= 8'd0;
      r_grant <= 4'b0000;
      r_sel   <= 2'd0;
      r_led   <= 3'b000;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_last  <= w_last_d;
      r_cnt   <= w_cnt_d;
      r_grant <= w_grant_d;
      r_sel   <= w_sel_d;
      r_led   <= w_led_d;
    end
  end

  assign grant = r_grant;
  assign sel   = r_sel;
  assign led   = r_led;
  assign busy  = (r_state == StHold);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: a cycle model of the arbitration rules is
// compared every cycle, plus directed literal expectations from the scenario list.
module tb_mux_rr_arbiter;

  localparam int unsigned Dwell = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [2:0] sw0 = 3'b000;
  logic [2:0] sw1 = 3'b000;
  logic [2:0] sw2 = 3'b000;
  logic [2:0] sw3 = 3'b000;
  logic [3:0] grant, grant1;
  logic [1:0] sel, sel1;
  logic [2:0] led, led1;
  logic       busy, busy1;

  int n_checks = 0;
  int n_errors = 0;

  mux_rr_arbiter #(.DWELL(Dwell)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .sw0(sw0), .sw1(sw1), .sw2(sw2), .sw3(sw3),
    .grant(grant), .sel(sel), .led(led), .busy(busy)
  );

  mux_rr_arbiter #(.DWELL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .sw0(sw0), .sw1(sw1), .sw2(sw2), .sw3(sw3),
    .grant(grant1), .sel(sel1), .led(led1), .busy(busy1)
  );

  always #5 clk = ~clk;

  // Behavioural model: who holds the LED, how long it has held it, and the rotation pointer.
  bit         m_valid = 1'b0;
  int         m_hold  = -1;
  int         m_held  = 0;
  int         m_ptr   = 3;
  logic [1:0] m_sel   = 2'd0;
  logic [3:0] m_grant = 4'b0000;
  logic [2:0] m_led   = 3'b000;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [2:0] sw_of(input int i);
    case (i)
      0: return sw0;
      1: return sw1;
      2: return sw2;
      default: return sw3;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b1;
      m_hold  = -1;
      m_held  = 0;
      m_ptr   = 3;
      m_sel   = 2'd0;
    end else if (m_hold < 0) begin
      if (req != 4'b0000) begin
        m_hold = pick(req, m_ptr);
        m_held = 1;
      end
    end else if (!req[m_hold] || m_held >= int'(Dwell)) begin
      m_ptr  = m_hold;
      m_hold = pick(req, m_hold);
      m_held = 1;
    end else begin
      m_held++;
    end
    if (m_hold >= 0) m_sel = 2'(m_hold);
    m_grant = (m_hold >= 0) ? 4'(1 << m_hold) : 4'b0000;
    m_led   = (m_hold >= 0) ? sw_of(m_hold) : 3'b000;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(posedge clk);
      #1;
      if (m_valid) begin
        check("model_grant", 32'(grant), 32'(m_grant));
        check("model_sel", 32'(sel), 32'(m_sel));
        check("model_led", 32'(led), 32'(m_led));
        check("model_busy", 32'(busy), 32'(m_hold >= 0));
      end
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0] req_tab [8] = '{4'b0110, 4'b0000, 4'b1001, 4'b1111,
                              4'b0100, 4'b1100, 4'b0011, 4'b0000};
  int         len_tab [8] = '{7, 2, 9, 13, 6, 5, 10, 3};

  initial begin
    fork
      compare_loop();
    join_none

    // Reset values
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_sel", 32'(sel), 32'h0);
    check("reset_led", 32'(led), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);

    // Single request: grant visible one cycle after req is sampled
    req = 4'b0100;
    sw2 = 3'b101;
    settle();
    check("t1_grant", 32'(grant), 32'h4);
    check("t1_sel", 32'(sel), 32'h2);
    check("t1_led", 32'(led), 32'h5);
    check("t1_busy", 32'(busy), 32'h1);

    // Live data tracking while bank 2 holds
    @(negedge clk);
    sw2 = 3'b001;
    settle();
    check("t5_led_a", 32'(led), 32'h1);
    @(negedge clk);
    sw2 = 3'b110;
    settle();
    check("t5_led_b", 32'(led), 32'h6);

    // Reset mid-HOLD, then arbitration restarts from bank 0
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b1010;
    settle();
    check("t5_rst_grant", 32'(grant), 32'h0);
    check("t5_rst_led", 32'(led), 32'h0);
    check("t5_rst_busy", 32'(busy), 32'h0);
    check("t5_rst_sel", 32'(sel), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    settle();
    check("t5_restart_grant", 32'(grant), 32'h2);

    // All requesting: DWELL=4 rotates every 4 cycles, DWELL=1 every cycle
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      settle();
      check("t2_rotate", 32'(grant), 32'(1 << ((k / 4) % 4)));
      check("t2_rotate_dwell1", 32'(grant1), 32'(1 << (k % 4)));
      check("t2_busy", 32'(busy), 32'h1);
    end

    // Sole requester is re-granted without an idle gap, then drops
    do_reset();
    req = 4'b0001;
    sw0 = 3'b011;
    for (int k = 0; k < 10; k++) begin
      settle();
      check("t3_grant", 32'(grant), 32'h1);
      check("t3_busy", 32'(busy), 32'h1);
    end
    @(negedge clk);
    req = 4'b0000;
    settle();
    check("t3_drop_grant", 32'(grant), 32'h0);
    check("t3_drop_led", 32'(led), 32'h0);
    check("t3_drop_busy", 32'(busy), 32'h0);

    // Grantee bank 1 drops after 2 cycles while bank 3 waits
    do_reset();
    req = 4'b1010;
    sw3 = 3'b011;
    settle();
    check("t4_first", 32'(grant), 32'h2);
    settle();
    @(negedge clk);
    req = 4'b1000;
    settle();
    check("t4_grant", 32'(grant), 32'h8);
    check("t4_sel", 32'(sel), 32'h3);
    check("t4_led", 32'(led), 32'h3);

    // Mixed directed patterns, checked by the model only
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      req = req_tab[s];
      for (int c = 0; c < len_tab[s]; c++) begin
        @(negedge clk);
        sw0 = 3'(s + c);
        sw1 = 3'(s * 3 + c);
        sw2 = 3'(7 - c);
        sw3 = 3'(s ^ c);
      end
    end

    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
